// File: rtl/ascon_inv_p.sv
// rtl/ascon_inv_p.sv - inverse Ascon permutation, one inverse round per clock (optional ASCON_INV_VARROUNDS_EN)
module ascon_inv_p #(
  parameter int NUM_ROUNDS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] S_0_in,
  input  logic [63:0] S_1_in,
  input  logic [63:0] S_2_in,
  input  logic [63:0] S_3_in,
  input  logic [63:0] S_4_in,
`ifdef ASCON_INV_VARROUNDS_EN
  input  logic [3:0]  num_rounds,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] S_0_out,
  output logic [63:0] S_1_out,
  output logic [63:0] S_2_out,
  output logic [63:0] S_3_out,
  output logic [63:0] S_4_out,
  output logic        busy
);

  typedef logic [4:0][63:0] state_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [3:0] ROUNDS = 4'(NUM_ROUNDS);

  fsm_t       state;
  state_t     st_q;
  state_t     round_out;
  logic [3:0] r;
  logic [3:0] op_rounds;
  logic [3:0] accept_rounds;
  logic [3:0] cidx;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // L = 1 + R^a + R^b in GF(2)[R]/(R^64+1) satisfies L^64 = 1, so
  // L^-1 = L^63 = product of L^(2^k), k=0..5, each of which is 1 + R^(a*2^k) + R^(b*2^k).
  function automatic logic [63:0] lin_inv(input logic [63:0] x, input int unsigned a,
                                          input int unsigned b);
    logic [63:0] y;
    y = x;
    for (int k = 0; k < 6; k++) begin
      y = y ^ ror64(y, (a << k) % 64) ^ ror64(y, (b << k) % 64);
    end
    return y;
  endfunction

  function automatic logic [4:0] inv_sbox(input logic [4:0] y);
    logic [4:0] x;
    case (y)
      5'h00: x = 5'h14; 5'h01: x = 5'h1a; 5'h02: x = 5'h07; 5'h03: x = 5'h0d;
      5'h04: x = 5'h00; 5'h05: x = 5'h09; 5'h06: x = 5'h0e; 5'h07: x = 5'h12;
      5'h08: x = 5'h0a; 5'h09: x = 5'h06; 5'h0a: x = 5'h1d; 5'h0b: x = 5'h01;
      5'h0c: x = 5'h19; 5'h0d: x = 5'h15; 5'h0e: x = 5'h13; 5'h0f: x = 5'h1e;
      5'h10: x = 5'h18; 5'h11: x = 5'h16; 5'h12: x = 5'h0b; 5'h13: x = 5'h11;
      5'h14: x = 5'h03; 5'h15: x = 5'h05; 5'h16: x = 5'h1c; 5'h17: x = 5'h1f;
      5'h18: x = 5'h17; 5'h19: x = 5'h1b; 5'h1a: x = 5'h04; 5'h1b: x = 5'h08;
      5'h1c: x = 5'h0f; 5'h1d: x = 5'h0c; 5'h1e: x = 5'h10; default: x = 5'h02;
    endcase
    return x;
  endfunction

  function automatic logic [7:0] round_const(input logic [3:0] i);
    logic [7:0] c;
    case (i)
      4'd0:  c = 8'h3c; 4'd1:  c = 8'h2d; 4'd2:  c = 8'h1e; 4'd3:  c = 8'h0f;
      4'd4:  c = 8'hf0; 4'd5:  c = 8'he1; 4'd6:  c = 8'hd2; 4'd7:  c = 8'hc3;
      4'd8:  c = 8'hb4; 4'd9:  c = 8'ha5; 4'd10: c = 8'h96; 4'd11: c = 8'h87;
      4'd12: c = 8'h78; 4'd13: c = 8'h69; 4'd14: c = 8'h5a; default: c = 8'h4b;
    endcase
    return c;
  endfunction

  function automatic state_t inv_round(input state_t s, input logic [7:0] c);
    state_t     l;
    state_t     o;
    logic [4:0] v;
    l[0] = lin_inv(s[0], 19, 28);
    l[1] = lin_inv(s[1], 61, 39);
    l[2] = lin_inv(s[2], 1, 6);
    l[3] = lin_inv(s[3], 10, 17);
    l[4] = lin_inv(s[4], 7, 41);
    o = '0;
    for (int i = 0; i < 64; i++) begin
      v = inv_sbox({l[0][i], l[1][i], l[2][i], l[3][i], l[4][i]});
      o[0][i] = v[4];
      o[1][i] = v[3];
      o[2][i] = v[2];
      o[3][i] = v[1];
      o[4][i] = v[0];
    end
    o[2][7:0] = o[2][7:0] ^ c;
    return o;
  endfunction

  // Constant index 16 - rounds + r, taken modulo 16 (always lands in 4..15).
  assign cidx = r - op_rounds;

`ifdef ASCON_INV_VARROUNDS_EN
  assign accept_rounds = ((num_rounds == 4'd0) || (num_rounds > 4'd12)) ? 4'd12 : num_rounds;

  // Latch the round count of the accepted operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_rounds <= ROUNDS;
    end else if (state == IDLE && in_valid) begin
      op_rounds <= accept_rounds;
    end
  end
`else
  assign accept_rounds = ROUNDS;
  assign op_rounds     = ROUNDS;
`endif

  // One inverse round of the current state register contents.
  always_comb begin
    round_out = inv_round(st_q, round_const(cidx));
  end

  // Control FSM with registered handshake flags; state words follow it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      st_q      <= '0;
      r         <= 4'd0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st_q     <= {S_4_in, S_3_in, S_2_in, S_1_in, S_0_in};
            r        <= accept_rounds - 4'd1;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          st_q <= round_out;
          r    <= (r == 4'd0) ? 4'd0 : r - 4'd1;
          if (r == 4'd0) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign S_0_out = st_q[0];
  assign S_1_out = st_q[1];
  assign S_2_out = st_q[2];
  assign S_3_out = st_q[3];
  assign S_4_out = st_q[4];

endmodule

// File: tb/tb_ascon_inv_p.sv
// tb/tb_ascon_inv_p.sv - scoreboard bench for ascon_inv_p against a forward Ascon model
module tb_ascon_inv_p;

  typedef logic [4:0][63:0] st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic in_valid_s  [2] = '{1'b0, 1'b0};
  logic in_ready_s  [2];
  logic out_valid_s [2];
  logic out_ready_s [2] = '{1'b0, 1'b0};
  logic busy_s      [2];
  st_t  din         [2] = '{'0, '0};
  st_t  dout        [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  logic prev_ov [2] = '{1'b0, 1'b0};
  st_t  exp_q [$];
  int   acc_q [$];

  logic [4:0] inv_tab [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02};
  logic [4:0] fwd_tab [32];
  logic [7:0] ctab [16] = '{
    8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
    8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

  ascon_inv_p #(.NUM_ROUNDS(12)) dut12 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .S_0_in(din[0][0]), .S_1_in(din[0][1]), .S_2_in(din[0][2]),
    .S_3_in(din[0][3]), .S_4_in(din[0][4]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .S_0_out(dout[0][0]), .S_1_out(dout[0][1]), .S_2_out(dout[0][2]),
    .S_3_out(dout[0][3]), .S_4_out(dout[0][4]),
    .busy(busy_s[0]));

  ascon_inv_p #(.NUM_ROUNDS(6)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .S_0_in(din[1][0]), .S_1_in(din[1][1]), .S_2_in(din[1][2]),
    .S_3_in(din[1][3]), .S_4_in(din[1][4]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .S_0_out(dout[1][0]), .S_1_out(dout[1][1]), .S_2_out(dout[1][2]),
    .S_3_out(dout[1][3]), .S_4_out(dout[1][4]),
    .busy(busy_s[1]));

  function automatic logic [63:0] ror(logic [63:0] x, int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Forward Ascon permutation: constant addition, S-box, linear diffusion.
  function automatic st_t fwd_perm(st_t x, int n);
    st_t s;
    logic [4:0] v;
    s = x;
    for (int i = 0; i < n; i++) begin
      s[2][7:0] = s[2][7:0] ^ ctab[16 - n + i];
      for (int j = 0; j < 64; j++) begin
        v = fwd_tab[{s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]}];
        {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]} = v;
      end
      s[0] = s[0] ^ ror(s[0], 19) ^ ror(s[0], 28);
      s[1] = s[1] ^ ror(s[1], 61) ^ ror(s[1], 39);
      s[2] = s[2] ^ ror(s[2], 1)  ^ ror(s[2], 6);
      s[3] = s[3] ^ ror(s[3], 10) ^ ror(s[3], 17);
      s[4] = s[4] ^ ror(s[4], 7)  ^ ror(s[4], 41);
    end
    return s;
  endfunction

  function automatic st_t rand_state();
    st_t x;
    for (int w = 0; w < 5; w++) x[w] = {$urandom, $urandom};
    return x;
  endfunction

  function automatic int nr(int k);
    return (k == 0) ? 12 : 6;
  endfunction

  task automatic chk(string nm, logic [319:0] act, logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Consumer readiness: random, forced low, or forced high.
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 2; k++)
      out_ready_s[k] = (ready_mode == 1) ? 1'b0 :
                       (ready_mode == 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record accepts, check latency on out_valid rise, check results on consume.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (in_valid_s[k] && in_ready_s[k]) begin
          exp_q.push_back(din[k]);
          acc_q.push_back(cyc + 1);
        end
        if (out_valid_s[k] && !prev_ov[k]) begin
          if (acc_q.size() == 0) chk("unexpected_out_valid", 1'b1, 1'b0);
          else chk("latency", 320'(cyc - acc_q.pop_front()), 320'(nr(k)));
        end
        if (out_valid_s[k] && out_ready_s[k]) begin
          if (exp_q.size() == 0) chk("unexpected_result", 1'b1, 1'b0);
          else chk("result_forward", fwd_perm(dout[k], nr(k)), exp_q.pop_front());
        end
        prev_ov[k] = out_valid_s[k];
      end
    end else begin
      prev_ov[0] = 1'b0;
      prev_ov[1] = 1'b0;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(int k, st_t y);
    int n;
    n = 0;
    while (!in_ready_s[k] && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      chk("issue_timeout", 1'b1, 1'b0);
    end else begin
      din[k] = y;
      in_valid_s[k] = 1'b1;
      @(posedge clk); #1;
      in_valid_s[k] = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", 320'(exp_q.size()), 320'd0);
  endtask

  initial begin
    st_t snap;
    int  n;
    logic seen;
    for (int y = 0; y < 32; y++) fwd_tab[inv_tab[y]] = 5'(y);

    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", in_ready_s[k], 1'b1);
      chk("rst_out_valid", out_valid_s[k], 1'b0);
      chk("rst_busy", busy_s[k], 1'b0);
      chk("rst_state", dout[k], '0);
    end
    #20;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    issue(0, '0);
    chk("accept_in_ready_low", in_ready_s[0], 1'b0);
    chk("accept_busy_high", busy_s[0], 1'b1);
    drain();

    for (int i = 0; i < 1000; i++) issue(0, fwd_perm(rand_state(), 12));
    drain();

    for (int i = 0; i < 40; i++) issue(1, fwd_perm(rand_state(), 6));
    drain();

    ready_mode = 1;
    issue(0, fwd_perm(rand_state(), 12));
    n = 0;
    while (!out_valid_s[0] && n < 50) begin
      @(negedge clk); n++;
    end
    chk("hold_reached_done", out_valid_s[0], 1'b1);
    snap = dout[0];
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid_s[0] = (i < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
      din[0] = rand_state();
      @(negedge clk);
      chk("hold_out_valid", out_valid_s[0], 1'b1);
      chk("hold_in_ready", in_ready_s[0], 1'b0);
      chk("hold_data", dout[0], snap);
    end
    @(posedge clk); #1;
    ready_mode = 2;
    @(posedge clk); #3;
    chk("release_in_ready", in_ready_s[0], 1'b1);
    chk("release_out_valid", out_valid_s[0], 1'b0);
    ready_mode = 0;
    drain();

    issue(0, fwd_perm(rand_state(), 12));
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_state", dout[0], '0);
    chk("midrst_in_ready", in_ready_s[0], 1'b1);
    chk("midrst_out_valid", out_valid_s[0], 1'b0);
    chk("midrst_busy", busy_s[0], 1'b0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) @(negedge clk) if (out_valid_s[0]) seen = 1'b1;
    chk("midrst_no_out_valid", seen, 1'b0);
    @(posedge clk); #1;
    issue(0, fwd_perm(rand_state(), 12));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascon_inv_p.md
ASCON_INV_P -- requirements
Module: ascon_inv_p

Interface
REQ-001 Parameter NUM_ROUNDS, default 12, meaning: inverse rounds per operation; legal 1..12.
REQ-002 clk  input  1  clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  input state S_0_in..S_4_in valid.
REQ-005 in_ready  output  1  block can accept a state.
REQ-006 S_0_in..S_4_in  input  64 each  state words to invert.
REQ-007 out_valid  output  1  S_0_out..S_4_out hold the finished result.
REQ-008 out_ready  input  1  consumer takes the result.
REQ-009 S_0_out..S_4_out  output  64 each  registered state words.
REQ-010 busy  output  1  high while rounds are executing.

Function
REQ-011 The block SHALL compute the inverse of the NUM_ROUNDS-round Ascon permutation, so that forward_p(inverse_p(X)) = X for every 320-bit X.
REQ-012 FSM states IDLE, RUN, DONE; in_ready = (state==IDLE); busy = (state==RUN); out_valid = (state==DONE).
REQ-013 IDLE: on in_valid at an edge, load S_k_in into the state registers, set round counter r = NUM_ROUNDS-1, go to RUN.
REQ-014 RUN: each edge applies one inverse round for index r, then decrements r; after the r==0 round go to DONE.
REQ-015 Inverse round order: first inverse linear layer, then inverse S-box, then constant removal.
REQ-016 Inverse linear layer: word k replaced by the unique 64-bit linear map Lk^-1 with Lk(Lk^-1(x)) = x, where Lk(x) = x ^ ror(x,a) ^ ror(x,b), (a,b) = (19,28),(61,39),(1,6),(10,17),(7,41) for k = 0..4.
REQ-017 Inverse S-box: per bit i, 5-bit value {S_0[i],S_1[i],S_2[i],S_3[i],S_4[i]} (S_0 MSB) mapped y->x: 00:14 01:1a 02:07 03:0d 04:00 05:09 06:0e 07:12 08:0a 09:06 0a:1d 0b:01 0c:19 0d:15 0e:13 0f:1e 10:18 11:16 12:0b 13:11 14:03 15:05 16:1c 17:1f 18:17 19:1b 1a:04 1b:08 1c:0f 1d:0c 1e:10 1f:02.
REQ-018 Constant removal: S_2[7:0] ^= C[16-NUM_ROUNDS+r], C[0..15] = 3c 2d 1e 0f f0 e1 d2 c3 b4 a5 96 87 78 69 5a 4b.
REQ-019 Latency: out_valid rises exactly NUM_ROUNDS cycles after the accepting edge.
REQ-020 DONE: outputs held stable until out_ready sampled high, then go to IDLE; in_valid ignored in RUN and DONE.
REQ-021 out_valid and out_ready high at same edge: result consumed, next cycle in_ready=1; no back-to-back acceptance in that edge.
REQ-022 S_k_out always equals the state registers (intermediate round values visible during RUN, not qualified).

Reset
REQ-023 rst_n low SHALL force IDLE, all state registers and S_k_out to 0, r to 0, out_valid=0, busy=0, in_ready=1, immediately and asynchronously.
REQ-024 Reset asserted mid-RUN or in DONE SHALL discard the operation; no out_valid pulse follows.

Configuration
REQ-025 Macro ASCON_INV_VARROUNDS_EN defined: extra input num_rounds (4 bits) sampled at the accepting edge replaces NUM_ROUNDS for that operation (including constant index and latency); values 0 or >12 treated as 12.
REQ-026 Macro undefined: no num_rounds port; NUM_ROUNDS parameter governs every operation.

Verification
REQ-027 Reset then in_valid=1, all inputs 0, NUM_ROUNDS=12 -> in_ready drops next cycle, out_valid high exactly 12 cycles after accept; forward model applied to result returns all-zero state.
REQ-028 Random 320-bit X, forward_p12(X) fed in -> S_k_out == X; repeat 1000 random vectors, zero mismatches.
REQ-029 NUM_ROUNDS=6 (or num_rounds=6 with macro): forward_p6(X) in -> X out, out_valid 6 cycles after accept; num_rounds=0 and 15 behave as 12.
REQ-030 out_ready held 0 for 20 cycles in DONE -> out_valid and S_k_out unchanged, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-031 rst_n pulsed low during round 5 -> S_k_out=0 and in_ready=1 immediately, no out_valid; new operation afterwards returns correct X.
